// File: rtl/cond_unit.sv
// Conditional-execution unit: evaluates the instruction condition against the
// registered NZCV flags, qualifies the write strobes, owns the flag and sticky
// Q registers, and sequences the one-cycle high-half writeback of long ops.
module cond_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [4:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       LongOp,
    input  logic       QClear,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags,
    output logic       QFlag,
    output logic       WriteHigh,
    output logic       Stall
);

    typedef enum logic {IDLE, HIGH} state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       qflag_q, qflag_d;
    logic       cond_ex;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags_q;
    assign Flags  = flags_q;
    assign QFlag  = qflag_q;
    assign CondEx = cond_ex;

    // Condition check uses only the registered flags, so flags written by one
    // instruction are seen by the next one with no bypass from the ALU.
    always_comb begin
        cond_ex = 1'b1;
        case (Cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            4'b1111: cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

    // Next-state, strobe qualification and flag/Q next values.
    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        qflag_d   = qflag_q;
        PCSrc     = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        WriteHigh = 1'b0;
        Stall     = 1'b0;
        case (state_q)
            IDLE: begin
                PCSrc    = PCS & cond_ex;
                RegWrite = RegW & cond_ex & ~NoWrite;
                MemWrite = MemW & cond_ex;
                // A long op writes the low half now and the high half next cycle.
                if (LongOp & RegW & cond_ex & ~NoWrite) begin
                    Stall   = 1'b1;
                    state_d = HIGH;
                end
                if (FlagW[1] & cond_ex) flags_d[3:2] = ALUFlags[3:2];
                if (FlagW[0] & cond_ex) flags_d[1:0] = ALUFlags[1:0];
                // Set is evaluated last so it wins over a coincident clear.
                if (QClear & cond_ex) qflag_d = 1'b0;
                if (ALUFlags[4] & cond_ex) qflag_d = 1'b1;
            end
            HIGH: begin
                // High-half writeback: inputs ignored, flags and Q hold.
                RegWrite  = 1'b1;
                WriteHigh = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, flag and sticky-Q registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            flags_q <= 4'b0000;
            qflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            qflag_q <= qflag_d;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed vectors push their expected outputs into a
// scoreboard queue; a monitor pops and compares on every falling edge.
module tb_cond_unit;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [4:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS, RegW, MemW, NoWrite, LongOp, QClear;
    logic       PCSrc, RegWrite, MemWrite, CondEx, QFlag, WriteHigh, Stall;
    logic [3:0] Flags;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } sb_t;

    sb_t  sbq[$];
    sb_t  mon_e;
    logic [10:0] got;
    int   checks = 0;
    int   errors = 0;

    cond_unit dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite), .LongOp(LongOp),
        .QClear(QClear), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .Flags(Flags), .QFlag(QFlag), .WriteHigh(WriteHigh),
        .Stall(Stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word layout: {PCSrc,RegWrite,MemWrite, CondEx, Stall,WriteHigh, Flags[3:0], QFlag}
    // ctl layout: {PCS,RegW,MemW,NoWrite,LongOp,QClear}
    task automatic step(input string nm, input logic r, input logic [3:0] c,
                        input logic [4:0] a, input logic [1:0] fw,
                        input logic [5:0] ctl, input logic [10:0] e);
        sb_t ent;
        @(posedge clk);
        #1;
        reset    = r;
        Cond     = c;
        ALUFlags = a;
        FlagW    = fw;
        {PCS, RegW, MemW, NoWrite, LongOp, QClear} = ctl;
        ent.name = nm;
        ent.exp  = e;
        sbq.push_back(ent);
    endtask

    // Monitor: one output observation per cycle, on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                mon_e = sbq.pop_front();
                got = {PCSrc, RegWrite, MemWrite, CondEx, Stall, WriteHigh, Flags, QFlag};
                checks++;
                if (got !== mon_e.exp) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", mon_e.name, got, mon_e.exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Cond = 4'b0; ALUFlags = 5'b0; FlagW = 2'b0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; LongOp = 0; QClear = 0;

        // Reset held: registers stay clear, outputs follow IDLE decode.
        step("rst_eq",        1, 4'b0000, 5'b00000, 2'b00, 6'b000000, 11'b000_0_00_0000_0);
        step("rst_al_pcs",    1, 4'b1110, 5'b11111, 2'b11, 6'b100000, 11'b100_1_00_0000_0);
        // First instruction after reset: Z=0.
        step("eq_after_rst",  0, 4'b0000, 5'b00000, 2'b00, 6'b000000, 11'b000_0_00_0000_0);
        step("ne_after_rst",  0, 4'b0001, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0000_0);
        // Full flag write then condition evaluation on the new flags.
        step("flagw11",       0, 4'b1110, 5'b01100, 2'b11, 6'b000000, 11'b000_1_00_0000_0);
        step("eq_z1",         0, 4'b0000, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_1100_0);
        step("ne_z1",         0, 4'b0001, 5'b00000, 2'b00, 6'b000000, 11'b000_0_00_1100_0);
        step("mi",            0, 4'b0100, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_1100_0);
        step("ge_n1v0",       0, 4'b1010, 5'b00000, 2'b00, 6'b000000, 11'b000_0_00_1100_0);
        step("ls_z1",         0, 4'b1001, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_1100_0);
        // Partial write: only C,V cleared.
        step("set1111",       0, 4'b1110, 5'b01111, 2'b11, 6'b000000, 11'b000_1_00_1100_0);
        step("partial_w01",   0, 4'b1110, 5'b00000, 2'b01, 6'b000000, 11'b000_1_00_1111_0);
        step("after_partial", 0, 4'b1111, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_1100_0);
        step("set_c_only",    0, 4'b1110, 5'b00010, 2'b11, 6'b000000, 11'b000_1_00_1100_0);
        step("hi",            0, 4'b1000, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0010_0);
        step("gt",            0, 4'b1100, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0010_0);
        step("le",            0, 4'b1101, 5'b00000, 2'b00, 6'b000000, 11'b000_0_00_0010_0);
        // Long op: low half with stall, then one HIGH cycle ignoring inputs.
        step("long_c0",       0, 4'b1110, 5'b00000, 2'b00, 6'b010010, 11'b010_1_10_0010_0);
        step("long_c1_high",  0, 4'b0000, 5'b11111, 2'b11, 6'b111111, 11'b010_0_01_0010_0);
        step("long_c2_idle",  0, 4'b1110, 5'b00000, 2'b00, 6'b111000, 11'b111_1_00_0010_0);
        // NoWrite blocks register write and the long-op transition.
        step("nowrite_long",  0, 4'b1110, 5'b00000, 2'b00, 6'b010110, 11'b000_1_00_0010_0);
        step("after_nowrite", 0, 4'b1110, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0010_0);
        // Failed condition suppresses everything.
        step("clear_flags",   0, 4'b1110, 5'b00000, 2'b11, 6'b000000, 11'b000_1_00_0010_0);
        step("failed_cond",   0, 4'b0000, 5'b11111, 2'b11, 6'b111010, 11'b000_0_00_0000_0);
        step("after_fail",    0, 4'b1110, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0000_0);
        // Sticky Q behaviour.
        step("q_set",         0, 4'b1110, 5'b10000, 2'b00, 6'b000000, 11'b000_1_00_0000_0);
        step("q_hold1",       0, 4'b1110, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0000_1);
        step("q_hold2",       0, 4'b1110, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0000_1);
        step("q_hold3",       0, 4'b1110, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0000_1);
        step("q_set_clr",     0, 4'b1110, 5'b10000, 2'b00, 6'b000001, 11'b000_1_00_0000_1);
        step("q_clr",         0, 4'b1110, 5'b00000, 2'b00, 6'b000001, 11'b000_1_00_0000_1);
        step("q_fail_set",    0, 4'b0000, 5'b10000, 2'b00, 6'b000000, 11'b000_0_00_0000_0);
        step("q_still0",      0, 4'b1110, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0000_0);
        // Reset during the HIGH cycle aborts it asynchronously.
        step("set_all",       0, 4'b1110, 5'b11111, 2'b11, 6'b000000, 11'b000_1_00_0000_0);
        step("long_pre_rst",  0, 4'b1110, 5'b00000, 2'b00, 6'b010010, 11'b010_1_10_1111_1);
        step("rst_in_high",   1, 4'b1110, 5'b00000, 2'b00, 6'b010010, 11'b010_1_10_0000_0);
        step("rst_held_eq",   1, 4'b0000, 5'b00000, 2'b00, 6'b000000, 11'b000_0_00_0000_0);
        step("gt_after_rst",  0, 4'b1100, 5'b00000, 2'b00, 6'b000000, 11'b000_1_00_0000_0);

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port Cond, input, 4, condition field of the executing instruction.
REQ-004 SHALL have port ALUFlags, input, 5, {Q,N,Z,C,V} from the ALU, same cycle.
REQ-005 SHALL have port FlagW, input, 2, flag write enables: [1] writes N,Z; [0] writes C,V.
REQ-006 SHALL have ports PCS, RegW, MemW, NoWrite, LongOp, QClear, each input, 1: decoder requests for PC write, register write, memory write, compare-only, 64-bit result, clear Q.
REQ-007 SHALL have ports PCSrc, RegWrite, MemWrite, input-gated outputs, 1 each: condition-qualified write strobes.
REQ-008 SHALL have port CondEx, output, 1, condition passed this cycle.
REQ-009 SHALL have port Flags, output, 4, registered {N,Z,C,V}; Flags[1] also feeds the ALU curr_carry_flag input.
REQ-010 SHALL have port QFlag, output, 1, registered sticky saturation flag.
REQ-011 SHALL have ports WriteHigh and Stall, output, 1 each: select Result2 for writeback; hold PC/fetch.

Function
REQ-012 SHALL evaluate CondEx combinationally from registered Flags (never from ALUFlags): EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); 1110 and 1111 both 1.
REQ-013 SHALL implement two states: IDLE and HIGH.
REQ-014 In IDLE, SHALL drive PCSrc=PCS&CondEx, RegWrite=RegW&CondEx&~NoWrite, MemWrite=MemW&CondEx, WriteHigh=0.
REQ-015 In IDLE, SHALL drive Stall=1 and go to HIGH at the next edge iff LongOp&RegW&CondEx&~NoWrite; otherwise Stall=0 and stay IDLE.
REQ-016 In HIGH, SHALL drive RegWrite=1, WriteHigh=1, Stall=0, PCSrc=0, MemWrite=0, ignore all inputs, and return to IDLE at the next edge (exactly one HIGH cycle).
REQ-017 In IDLE, on the edge, SHALL load Flags[3:2] from ALUFlags[3:2] iff FlagW[1]&CondEx, and Flags[1:0] from ALUFlags[1:0] iff FlagW[0]&CondEx; unselected bits hold.
REQ-018 In HIGH, SHALL hold Flags unchanged.
REQ-019 SHALL set QFlag on the edge when in IDLE with ALUFlags[4]&CondEx, independent of FlagW; QFlag SHALL otherwise hold.
REQ-020 SHALL clear QFlag on the edge when QClear&CondEx in IDLE; if set and clear coincide, set SHALL win.
REQ-021 A failed condition SHALL suppress all strobes, flag updates, Q updates and the HIGH transition.
REQ-022 Flags written by instruction k SHALL be visible to CondEx of instruction k+1 (one-cycle latency, no bypass).

Reset
REQ-023 Reset SHALL force state IDLE, Flags=4'b0000, QFlag=0 immediately, regardless of clock.
REQ-024 Reset asserted during HIGH SHALL abort the high-half write; outputs SHALL reflect IDLE decode while reset is high.
REQ-025 After reset, Z=0 so Cond=EQ SHALL fail and Cond=NE SHALL pass on the first instruction.

Verification
REQ-026 Flag write: FlagW=11, Cond=1110, ALUFlags=5'b01100 -> next cycle Flags=1100; then Cond=0000 -> CondEx=1, Cond=0001 -> CondEx=0.
REQ-027 Partial write: Flags=1111, FlagW=01, ALUFlags=5'b00000, Cond=AL -> Flags=1100.
REQ-028 Long op: LongOp=1, RegW=1, Cond=AL -> cycle0 RegWrite=1, Stall=1, WriteHigh=0; cycle1 RegWrite=1, WriteHigh=1, Stall=0; cycle2 back to IDLE decode.
REQ-029 Failed cond: Flags=0000, Cond=0000, PCS=RegW=MemW=LongOp=1, FlagW=11, ALUFlags=5'b11111 -> all strobes 0, Stall=0, Flags and QFlag unchanged.
REQ-030 Sticky Q: ALUFlags[4]=1, FlagW=00, Cond=AL -> QFlag=1; three further instructions with Q=0 -> QFlag stays 1; QClear=1 with ALUFlags[4]=1 -> QFlag=1; QClear=1 alone -> QFlag=0.
REQ-031 Reset mid-operation: assert reset during HIGH cycle -> Flags=0000, QFlag=0, WriteHigh=0 asynchronously; after release, GT with Flags=0000 -> CondEx=1.
